// File: rtl/fade_sequencer.sv
// ============================================================================
// fade_sequencer: hue-wheel / breathe step sequencer that drives the R/G/B
// fade channel states. Rev 1.0 - initial release.
// ============================================================================
`default_nettype none

module fade_sequencer #(
  parameter int STEP_CYCLES = 2_000_000,
  parameter int TW          = $clog2(STEP_CYCLES)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       dir,
  input  logic       mode,
  input  logic       step_req,
  output logic [1:0] state_r,
  output logic [1:0] state_g,
  output logic [1:0] state_b,
  output logic [2:0] step_idx,
  output logic       step_tick
);

  localparam logic [1:0] ST_INC  = 2'b00;
  localparam logic [1:0] ST_DEC  = 2'b01;
  localparam logic [1:0] ST_HIGH = 2'b10;
  localparam logic [1:0] ST_LOW  = 2'b11;

  localparam logic [TW-1:0] TIMER_TERM = TW'(STEP_CYCLES - 1);
  localparam logic [2:0]    IDX_LAST   = 3'd5;
  localparam logic [5:0]    ROW0_FWD   = {ST_HIGH, ST_INC, ST_LOW};

  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    idx_q, idx_d;
  logic [5:0]    states_q, states_d;
  logic          tick_q, tick_d;
  logic          mode_q, mode_d;

  logic          mode_chg;
  logic          term;
  logic          advance;

  function automatic logic [1:0] swap_ramp(input logic [1:0] st);
    // Only the ramp states flip direction; holds stay put.
    swap_ramp = st[1] ? st : {1'b0, ~st[0]};
  endfunction

  function automatic logic [5:0] row_lut(input logic [2:0] idx, input logic rev,
                                         input logic brth);
    logic [5:0] row;
    row = ROW0_FWD;
    if (brth) begin
      row = idx[0] ? {ST_DEC, ST_DEC, ST_DEC} : {ST_INC, ST_INC, ST_INC};
    end else begin
      case (idx)
        3'd0:    row = {ST_HIGH, ST_INC,  ST_LOW };
        3'd1:    row = {ST_DEC,  ST_HIGH, ST_LOW };
        3'd2:    row = {ST_LOW,  ST_HIGH, ST_INC };
        3'd3:    row = {ST_LOW,  ST_DEC,  ST_HIGH};
        3'd4:    row = {ST_INC,  ST_LOW,  ST_HIGH};
        3'd5:    row = {ST_HIGH, ST_LOW,  ST_DEC };
        default: row = ROW0_FWD;
      endcase
      if (rev) begin
        row = {swap_ramp(row[5:4]), swap_ramp(row[3:2]), swap_ramp(row[1:0])};
      end
    end
    row_lut = row;
  endfunction

  always_comb begin
    mode_chg = (mode != mode_q);
    term     = en && (timer_q == TIMER_TERM);
    advance  = term || (!en && step_req);
    mode_d   = mode;

    timer_d = timer_q;
    if (mode_chg) begin
      timer_d = '0;
    end else if (en) begin
      timer_d = term ? '0 : timer_q + TW'(1);
    end

    idx_d = idx_q;
    if (mode_chg) begin
      idx_d = 3'd0;
    end else if (advance) begin
      if (mode) begin
        idx_d = {2'b00, ~idx_q[0]};
      end else if (dir) begin
        idx_d = (idx_q == 3'd0 || idx_q > IDX_LAST) ? IDX_LAST : idx_q - 3'd1;
      end else begin
        idx_d = (idx_q >= IDX_LAST) ? 3'd0 : idx_q + 3'd1;
      end
    end

    // With en low the outputs freeze unless a manual step or mode switch lands.
    states_d = states_q;
    if (en || step_req || mode_chg) begin
      states_d = row_lut(idx_d, dir, mode);
    end

    tick_d = advance && !mode_chg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q  <= '0;
      idx_q    <= 3'd0;
      states_q <= ROW0_FWD;
      tick_q   <= 1'b0;
      mode_q   <= 1'b0;
    end else begin
      timer_q  <= timer_d;
      idx_q    <= idx_d;
      states_q <= states_d;
      tick_q   <= tick_d;
      mode_q   <= mode_d;
    end
  end

  assign state_r   = states_q[5:4];
  assign state_g   = states_q[3:2];
  assign state_b   = states_q[1:0];
  assign step_idx  = idx_q;
  assign step_tick = tick_q;

endmodule

`default_nettype wire

// File: tb/tb_fade_sequencer.sv
// ============================================================================
// tb_fade_sequencer: directed self-checking bench for fade_sequencer with
// STEP_CYCLES=4. Rev 1.0 - initial release.
// ============================================================================
`default_nettype none

module tb_fade_sequencer;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       dir;
  logic       mode;
  logic       step_req;
  logic [1:0] state_r;
  logic [1:0] state_g;
  logic [1:0] state_b;
  logic [2:0] step_idx;
  logic       step_tick;

  int n_tests;
  int n_fail;

  logic [5:0] fwd_row [6];

  fade_sequencer #(.STEP_CYCLES(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .dir       (dir),
    .mode      (mode),
    .step_req  (step_req),
    .state_r   (state_r),
    .state_g   (state_g),
    .state_b   (state_b),
    .step_idx  (step_idx),
    .step_tick (step_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] exp_idx,
                           input logic [5:0] exp_sts, input logic exp_tick);
    check_eq({tag, " idx"},  32'(step_idx), 32'(exp_idx));
    check_eq({tag, " rgb"},  32'({state_r, state_g, state_b}), 32'(exp_sts));
    check_eq({tag, " tick"}, 32'(step_tick), 32'(exp_tick));
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    fwd_row[0] = 6'b10_00_11;
    fwd_row[1] = 6'b01_10_11;
    fwd_row[2] = 6'b11_10_00;
    fwd_row[3] = 6'b11_01_10;
    fwd_row[4] = 6'b00_11_10;
    fwd_row[5] = 6'b10_11_01;

    rst_n = 1'b0; en = 1'b1; dir = 1'b0; mode = 1'b0; step_req = 1'b0;

    // 1: reset state and first step
    step(2);
    check_all("reset", 3'd0, 6'b10_00_11, 1'b0);
    rst_n = 1'b1;
    step(3);
    check_all("t1 pre", 3'd0, 6'b10_00_11, 1'b0);
    step(1);
    check_all("t1 adv", 3'd1, 6'b01_10_11, 1'b1);

    // 2: free-run forward around the wheel back to 0
    for (int s = 0; s < 5; s++) begin
      step(3);
      check_eq("t2 quiet tick", 32'(step_tick), 32'd0);
      step(1);
      check_all($sformatf("t2 step%0d", (s + 2) % 6), 3'((s + 2) % 6),
                fwd_row[(s + 2) % 6], 1'b1);
    end

    // 3: reverse direction
    dir = 1'b1;
    step(1);
    check_all("t3 dirflip", 3'd0, 6'b10_01_11, 1'b0);
    step(3);
    check_all("t3 idx5", 3'd5, 6'b10_11_00, 1'b1);
    step(4);
    check_all("t3 idx4", 3'd4, 6'b01_11_10, 1'b1);

    // 4: freeze and manual step
    en = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      check_all("t4 frozen", 3'd4, 6'b01_11_10, 1'b0);
    end
    step_req = 1'b1;
    step(1);
    check_all("t4 manual", 3'd3, 6'b11_00_10, 1'b1);
    step_req = 1'b0;
    step(1);
    check_all("t4 after", 3'd3, 6'b11_00_10, 1'b0);
    en = 1'b1; step_req = 1'b1;
    step(1);
    check_all("t4 req ignored", 3'd3, 6'b11_00_10, 1'b0);
    step_req = 1'b0; dir = 1'b0;
    step(1);
    check_all("t4 dir fwd", 3'd3, 6'b11_01_10, 1'b0);

    // 5: switch to breathe mid-step
    mode = 1'b1;
    step(1);
    check_all("t5 modechg", 3'd0, 6'b00_00_00, 1'b0);
    step(3);
    check_eq("t5 quiet tick", 32'(step_tick), 32'd0);
    step(1);
    check_all("t5 dec", 3'd1, 6'b01_01_01, 1'b1);
    step(4);
    check_all("t5 inc", 3'd0, 6'b00_00_00, 1'b1);

    // 6: async reset mid-cycle
    #3;
    rst_n = 1'b0;
    #1;
    check_all("t6 async rst", 3'd0, 6'b10_00_11, 1'b0);
    mode = 1'b0; dir = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step(3);
    check_all("t6 restart", 3'd0, 6'b10_00_11, 1'b0);
    step(1);
    check_all("t6 adv", 3'd1, 6'b01_10_11, 1'b1);
    step(1);
    check_eq("t6 tick width", 32'(step_tick), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
